// File: rtl/game_step_scheduler_if.sv
// Handshake bundle between the game step scheduler, the UI/display/engine side and the grid.
// The master drives the request pulses; the slave is the scheduler that issues commands.
interface game_step_scheduler_if #(
    parameter int unsigned FRAME_W = 8
);
    logic               run_toggle;
    logic               single_step;
    logic               reload;
    logic               frame_sync;
    logic               step_done;
    logic               load_pattern;
    logic               step_game;
    logic [FRAME_W-1:0] frame;
    logic               running;
    logic               busy;

    modport master (
        output run_toggle, single_step, reload, frame_sync, step_done,
        input  load_pattern, step_game, frame, running, busy
    );

    modport slave (
        input  run_toggle, single_step, reload, frame_sync, step_done,
        output load_pattern, step_game, frame, running, busy
    );
endinterface

// File: rtl/game_step_scheduler.sv
// Paces game-of-life generations: free-running tick timer or single steps, each step released
// only on a display frame_sync so grid updates never tear a refresh pass.
// LOAD: pulse load_pattern | RUN: count ticks | PAUSE: await single_step | ARM: await frame_sync | WAIT: await step_done
module game_step_scheduler #(
    parameter int unsigned FRAME_TICKS = 1200000,
    parameter int unsigned FRAME_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    game_step_scheduler_if.slave  bus
);
    localparam int unsigned          TICK_W    = $clog2(FRAME_TICKS);
    localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(FRAME_TICKS - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_ARM,
        S_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               running_q, running_d;
    logic               load_pattern_q, load_pattern_d;
    logic               step_game_q, step_game_d;
    logic               busy_q, busy_d;
    logic               toggle;

    // reload outranks run_toggle, and LOAD ignores it
    assign toggle = bus.run_toggle && (state_q != S_LOAD) && !bus.reload;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= S_LOAD;
            tick_q         <= '0;
            frame_q        <= '0;
            running_q      <= 1'b1;
            load_pattern_q <= 1'b0;
            step_game_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_q         <= tick_d;
            frame_q        <= frame_d;
            running_q      <= running_d;
            load_pattern_q <= load_pattern_d;
            step_game_q    <= step_game_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        frame_d   = frame_q;
        running_d = running_q ^ toggle;

        case (state_q)
            S_LOAD:  state_d = running_q ? S_RUN : S_PAUSE;
            S_RUN: begin
                tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
                if (toggle)                  state_d = S_PAUSE;
                else if (tick_q == TICK_LAST) state_d = S_ARM;
            end
            S_PAUSE: begin
                if (toggle)               state_d = S_RUN;
                else if (bus.single_step) state_d = S_ARM;
            end
            S_ARM: begin
                if (bus.frame_sync) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.step_done) begin
                    frame_d = frame_q + FRAME_W'(1);
                    state_d = running_d ? S_RUN : S_PAUSE;
                end
            end
            default: state_d = S_LOAD;
        endcase

        if (bus.reload) state_d = S_LOAD;

        if ((state_d == S_RUN) && (state_q != S_RUN)) tick_d = '0;
        if ((state_d == S_LOAD) || (state_q == S_LOAD)) frame_d = '0;

        load_pattern_d = (state_q == S_LOAD);
        step_game_d    = (state_q == S_ARM) && (state_d == S_WAIT);
        busy_d         = (state_d == S_ARM) || (state_d == S_WAIT);
    end

    assign bus.load_pattern = load_pattern_q;
    assign bus.step_game    = step_game_q;
    assign bus.frame        = frame_q;
    assign bus.running      = running_q;
    assign bus.busy         = busy_q;
endmodule
